fir_coeff_ctrl: RTL and testbench
=================================

FIR_COEFF_CTRL -- requirements
Module: fir_coeff_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_COEFF, default 25, giving the number of 5x5 kernel taps.
REQ-002 The block SHALL have parameter COEFF_W, default 8, giving the width of each signed two's-complement coefficient.
REQ-003 The block SHALL have one clock, `clk`, and SHALL run entirely in that domain.
REQ-004 The block SHALL have reset `rst`, input, 1 bit, synchronous and active-low.
REQ-005 The block SHALL have the AXI-Lite write-address channel:
  - `axi_awaddr`, input, 32 bits
  - `axi_awvalid`, input, 1 bit
  - `axi_awready`, output, 1 bit
REQ-006 The block SHALL have the AXI-Lite write-data channel:
  - `axi_wdata`, input, 32 bits
  - `axi_wstrb`, input, 4 bits
  - `axi_wvalid`, input, 1 bit
  - `axi_wready`, output, 1 bit
REQ-007 The block SHALL have the AXI-Lite write-response channel:
  - `axi_bresp`, output, 2 bits
  - `axi_bvalid`, output, 1 bit
  - `axi_bready`, input, 1 bit
REQ-008 The block SHALL have `vs_i`, input, 1 bit: vertical sync of the video stream, used as the frame boundary.
REQ-009 The block SHALL have `coeff_o`, output, NUM_COEFF*COEFF_W bits: the active kernel, with tap k at bits [k*COEFF_W +: COEFF_W], taps row-major.
REQ-010 The block SHALL have `shift_o`, output, 4 bits: the active right-shift normalisation for the filter sum.
REQ-011 The block SHALL have `coeff_upd_o`, output, 1 bit: a one-cycle pulse when the active set changes.
REQ-012 The block SHALL have `pending_o`, output, 1 bit: high while a committed shadow set is waiting for a frame boundary.

Function
REQ-013 Address decode SHALL use word index `awaddr[7:2]`; `awaddr[31:8]` and `awaddr[1:0]` SHALL be ignored.
  - index 0..24: shadow coefficient k, taken from `wdata[COEFF_W-1:0]`
  - index 25: shadow shift, taken from `wdata[3:0]`
  - index 26: control; `wdata[0]`=1 is a commit request
  - index 27..63: invalid
REQ-014 `axi_awready` SHALL be high when no address is latched and `axi_bvalid` is low; an AW handshake SHALL latch `awaddr`.
REQ-015 `axi_wready` SHALL be high when no data is latched and `axi_bvalid` is low; a W handshake SHALL latch `wdata` and `wstrb`.
REQ-016 AW and W SHALL be accepted in either order or in the same cycle.
REQ-017 The register write SHALL occur in the cycle after both address and data are held; `axi_bvalid` SHALL rise in that same cycle and both latches SHALL clear.
REQ-018 `axi_bvalid` SHALL hold until `axi_bready` is high; no new AW or W SHALL be accepted while `axi_bvalid` is high.
REQ-019 `axi_bresp` SHALL be 2'b00 (OKAY) for index 0..26 and 2'b10 (SLVERR) for invalid indices; invalid-index writes SHALL change no state.
REQ-020 Writes SHALL take effect only when `wstrb[0]`=1; otherwise there SHALL be no state change and the response SHALL still be OKAY.
REQ-021 A commit write SHALL set the pending flag; re-committing while pending SHALL keep it set.
REQ-022 Shadow writes SHALL remain allowed while pending; the values copied SHALL be those in the shadow registers at the boundary cycle.
REQ-023 The frame boundary SHALL be the rising edge of `vs_i`, detected against a registered copy: `vs_i`=1 and `vs_q`=0.
REQ-024 On a frame boundary with pending set, in that cycle:
  - all shadow taps and shift SHALL be copied to the active registers
  - pending SHALL clear
  - `coeff_upd_o` SHALL pulse high exactly one cycle later, with the new values visible on `coeff_o` and `shift_o` from that same cycle
REQ-025 A frame boundary with pending clear SHALL produce no change and no pulse.
REQ-026 If a commit write and a frame boundary occur in the same cycle, pending SHALL be set and the copy SHALL wait for the next boundary.
REQ-027 If a shadow write and a copy occur in the same cycle, the copy SHALL use the pre-write shadow value.
REQ-028 `pending_o` SHALL equal the pending flag.
REQ-029 Active registers SHALL change only through the frame-boundary copy (REQ-024).

Reset
REQ-030 When `rst`=0 at a clock edge, the active and shadow registers SHALL reset to: tap 12 = 16, all other taps = 0, shift = 4 (pass-through kernel).
REQ-031 When `rst`=0 at a clock edge:
  - pending, latches, `vs_q`, `axi_bvalid`, `coeff_upd_o` SHALL = 0
  - `axi_bresp` SHALL = 2'b00
  - `axi_awready` and `axi_wready` SHALL = 1 in the first cycle after reset
REQ-032 A reset asserted mid-transaction SHALL drop any outstanding response with no AXI completion, and SHALL discard any pending commit.

Verification
REQ-033 Reset release: `coeff_o` tap12=16, others 0, `shift_o`=4, `pending_o`=0, `axi_awready`=`axi_wready`=1.
REQ-034 Write addr 0x00 data 0xFF, then addr 0x68 data 1 -> `pending_o`=1 and `coeff_o` unchanged; `vs_i` 0->1 -> the next cycle shows tap0=0xFF (-1) and a one-cycle `coeff_upd_o`.
REQ-035 W presented 3 cycles before AW (addr 0x64, data 5) -> `axi_bvalid` one cycle after AW; hold `axi_bready`=0 for 4 cycles -> `axi_bvalid` stays high, `axi_awready`=`axi_wready`=0.
REQ-036 Write to addr 0x70 -> `axi_bresp`=2'b10 and no register change; write to addr 0x04 with `wstrb`=4'b1110 -> OKAY and tap1 unchanged.
REQ-037 Commit write completing in the same cycle as a `vs_i` rising edge -> no copy on that edge; copy happens on the following edge.
REQ-038 Commit, then assert `rst`=0 before any `vs_i` edge -> `pending_o`=0, active set at reset values, and no `coeff_upd_o` on the subsequent `vs_i` edge.

Source files
------------

// File: rtl/fir_coeff_ctrl.sv
// ---------------------------------------------------------------------------
// fir_coeff_ctrl
//   AXI-Lite (write-only) controlled coefficient store for a 5x5 FIR kernel.
//   Software writes a shadow set of taps and a shift, then issues a commit.
//   At the next rising edge of vs_i the whole shadow set moves into the active
//   set at once, so the filter never sees a half-updated kernel in a frame.
//
//   Ports
//     clk, rst         : clock, synchronous active-low reset
//     axi_aw* / axi_w* : write address / data channels (either order)
//     axi_b*           : write response (OKAY, or SLVERR for bad index)
//     vs_i             : vertical sync, rising edge = frame boundary
//     coeff_o          : active taps, tap k at [k*COEFF_W +: COEFF_W]
//     shift_o          : active normalisation shift
//     coeff_upd_o      : one-cycle pulse, first cycle the new set is visible
//     pending_o        : committed shadow set waiting for a boundary
//
//   Register map (word index = awaddr[7:2]):
//     0..NUM_COEFF-1 : shadow tap, NUM_COEFF : shadow shift,
//     NUM_COEFF+1    : control (bit0 = commit), above : SLVERR
// ---------------------------------------------------------------------------

// One shadow/active register pair. The copy reads the shadow value from
// before any same-cycle write, which is what non-blocking order gives us.
module fir_coeff_tap #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         copy,
  output logic [W-1:0] active
);
  logic [W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= RST_VAL;
      active <= RST_VAL;
    end else begin
      if (wr_en) shadow <= wr_data;
      if (copy)  active <= shadow;
    end
  end
endmodule

module fir_coeff_ctrl #(
  parameter int NUM_COEFF = 25,
  parameter int COEFF_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  axi_awaddr,
  input  logic                         axi_awvalid,
  output logic                         axi_awready,
  input  logic [31:0]                  axi_wdata,
  input  logic [3:0]                   axi_wstrb,
  input  logic                         axi_wvalid,
  output logic                         axi_wready,
  output logic [1:0]                   axi_bresp,
  output logic                         axi_bvalid,
  input  logic                         axi_bready,
  input  logic                         vs_i,
  output logic [NUM_COEFF*COEFF_W-1:0] coeff_o,
  output logic [3:0]                   shift_o,
  output logic                         coeff_upd_o,
  output logic                         pending_o
);
  // Data latch must cover both a tap and the 4-bit shift field.
  localparam int         DW        = (COEFF_W > 4) ? COEFF_W : 4;
  localparam int         CENTER    = NUM_COEFF / 2;
  localparam logic [5:0] IDX_SHIFT = 6'(NUM_COEFF);
  localparam logic [5:0] IDX_CTRL  = 6'(NUM_COEFF + 1);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLV  = 2'b10;

  typedef struct packed {
    logic [5:0] idx;
  } aw_req_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          strb0;
  } w_req_t;

  aw_req_t    aw_q;
  w_req_t     w_q;
  logic       aw_held, w_held;
  logic       bvalid_q;
  logic [1:0] bresp_q;
  logic       pending_q, vs_q, upd_q;

  logic aw_hs, w_hs, do_wr, idx_ok, wr_en, commit_wr, boundary, copy;

  // Only low byte lane and word index bits carry meaning.
  logic unused_bits;
  assign unused_bits = ^{axi_awaddr[31:8], axi_awaddr[1:0],
                         axi_wdata[31:DW], axi_wstrb[3:1]};

  assign axi_awready = !aw_held && !bvalid_q;
  assign axi_wready  = !w_held  && !bvalid_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign coeff_upd_o = upd_q;
  assign pending_o   = pending_q;

  assign aw_hs     = axi_awvalid && axi_awready;
  assign w_hs      = axi_wvalid  && axi_wready;
  assign do_wr     = aw_held && w_held;
  assign idx_ok    = aw_q.idx <= IDX_CTRL;
  assign wr_en     = do_wr && idx_ok && w_q.strb0;
  assign commit_wr = wr_en && (aw_q.idx == IDX_CTRL) && w_q.data[0];
  assign boundary  = vs_i && !vs_q;
  // A commit landing on the boundary itself defers the copy to the next one.
  assign copy      = boundary && pending_q && !commit_wr;

  // Payload latches; qualified by the held flags, so no reset needed.
  always_ff @(posedge clk) begin
    if (aw_hs) aw_q.idx <= axi_awaddr[7:2];
    if (w_hs) begin
      w_q.data  <= axi_wdata[DW-1:0];
      w_q.strb0 <= axi_wstrb[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pending_q <= 1'b0;
      vs_q      <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      vs_q  <= vs_i;
      upd_q <= copy;
      if (do_wr) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= idx_ok ? RESP_OKAY : RESP_SLV;
      end else begin
        if (aw_hs) aw_held <= 1'b1;
        if (w_hs)  w_held  <= 1'b1;
        if (bvalid_q && axi_bready) bvalid_q <= 1'b0;
      end
      if (commit_wr)  pending_q <= 1'b1;
      else if (copy)  pending_q <= 1'b0;
    end
  end

  // Reset kernel is pass-through: unity gain 16 at the centre, shift 4.
  for (genvar k = 0; k < NUM_COEFF; k++) begin : g_tap
    fir_coeff_tap #(
      .W       (COEFF_W),
      .RST_VAL ((k == CENTER) ? COEFF_W'(16) : COEFF_W'(0))
    ) u_tap (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en && (aw_q.idx == 6'(k))),
      .wr_data (w_q.data[COEFF_W-1:0]),
      .copy    (copy),
      .active  (coeff_o[k*COEFF_W +: COEFF_W])
    );
  end

  fir_coeff_tap #(
    .W       (4),
    .RST_VAL (4'd4)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en && (aw_q.idx == IDX_SHIFT)),
    .wr_data (w_q.data[3:0]),
    .copy    (copy),
    .active  (shift_o)
  );
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_ctrl
//   Directed bench. Write responses and kernel-update events are expected
//   through two queues; independent monitors pop and compare whenever the DUT
//   presents a B handshake or a coeff_upd_o pulse. Inputs change 1 time unit
//   after posedge, outputs are sampled on negedge.
// ---------------------------------------------------------------------------
module tb_fir_coeff_ctrl;
  localparam int NC = 25;
  localparam int CW = 8;
  localparam int VW = NC * CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   axi_awaddr = '0;
  logic          axi_awvalid = 1'b0;
  logic          axi_awready;
  logic [31:0]   axi_wdata = '0;
  logic [3:0]    axi_wstrb = '0;
  logic          axi_wvalid = 1'b0;
  logic          axi_wready;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready = 1'b0;
  logic          vs_i = 1'b0;
  logic [VW-1:0] coeff_o;
  logic [3:0]    shift_o;
  logic          coeff_upd_o;
  logic          pending_o;

  always #5 clk = ~clk;

  fir_coeff_ctrl #(.NUM_COEFF(NC), .COEFF_W(CW)) dut (
    .clk(clk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .vs_i(vs_i), .coeff_o(coeff_o), .shift_o(shift_o),
    .coeff_upd_o(coeff_upd_o), .pending_o(pending_o)
  );

  typedef struct {
    logic [VW-1:0] vec;
    logic [3:0]    sh;
  } upd_t;

  logic [1:0] bq[$];
  upd_t       uq[$];
  upd_t       upd_e;
  int         cmp_cnt = 0;
  int         err_cnt = 0;

  logic [VW-1:0] rst_vec;
  logic [VW-1:0] exp_vec;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_now(string nm);
    cmp_cnt++;
    err_cnt++;
    $display("FAIL %s", nm);
  endfunction

  // Response monitor
  always @(negedge clk) begin
    if (rst && axi_bvalid && axi_bready) begin
      if (bq.size() == 0) fail_now("bresp_unexpected");
      else chk("bresp", 256'(axi_bresp), 256'(bq.pop_front()));
    end
  end

  // Kernel update monitor
  always @(negedge clk) begin
    if (coeff_upd_o) begin
      if (uq.size() == 0) fail_now("coeff_upd_unexpected");
      else begin
        upd_e = uq.pop_front();
        chk("upd_coeff", 256'(coeff_o), 256'(upd_e.vec));
        chk("upd_shift", 256'(shift_o), 256'(upd_e.sh));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] r);
    bit aw_ok = 1'b0;
    bit w_ok  = 1'b0;
    bit got   = 1'b0;
    int n     = 0;
    bq.push_back(r);
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(negedge clk);
      if (axi_awvalid && axi_awready) aw_ok = 1'b1;
      if (axi_wvalid && axi_wready)   w_ok  = 1'b1;
      tick();
      if (aw_ok) axi_awvalid = 1'b0;
      if (w_ok)  axi_wvalid  = 1'b0;
      n++;
    end
    if (!(aw_ok && w_ok)) fail_now("aw_w_accept_timeout");
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = axi_bvalid;
      tick();
      n++;
    end
    if (!got) fail_now("bvalid_timeout");
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
  endtask

  task automatic vs_edge();
    vs_i = 1'b1;
    tick();
    tick();
    vs_i = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_vec = '0;
    rst_vec[12*CW +: CW] = 8'd16;

    // Reset and release
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_coeff",   256'(coeff_o), 256'(rst_vec));
    chk("rst_shift",   256'(shift_o), 256'(4'd4));
    chk("rst_pending", 256'(pending_o), 256'(0));
    chk("rst_awready", 256'(axi_awready), 256'(1));
    chk("rst_wready",  256'(axi_wready), 256'(1));
    chk("rst_bvalid",  256'(axi_bvalid), 256'(0));
    chk("rst_upd",     256'(coeff_upd_o), 256'(0));
    tick();

    // Tap0 = -1, commit, then frame boundary
    axi_wr(32'h00, 32'hFF, 4'hF, 2'b00);
    axi_wr(32'h68, 32'h1,  4'hF, 2'b00);
    @(negedge clk);
    chk("commit_pending", 256'(pending_o), 256'(1));
    chk("commit_no_change", 256'(coeff_o), 256'(rst_vec));
    exp_vec = rst_vec;
    exp_vec[0 +: CW] = 8'hFF;
    uq.push_back('{vec: exp_vec, sh: 4'd4});
    tick();
    vs_i = 1'b1;
    @(negedge clk);
    chk("boundary_cycle_upd", 256'(coeff_upd_o), 256'(0));
    chk("boundary_cycle_coeff", 256'(coeff_o), 256'(rst_vec));
    tick();
    @(negedge clk);
    chk("copy_upd_pulse", 256'(coeff_upd_o), 256'(1));
    chk("copy_pending_clr", 256'(pending_o), 256'(0));
    tick();
    vs_i = 1'b0;
    tick();

    // W three cycles ahead of AW (shift = 5), B held off for 4 cycles
    axi_bready = 1'b0;
    axi_wdata = 32'h5; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
    @(negedge clk);
    chk("w_first_wready", 256'(axi_wready), 256'(1));
    tick();
    axi_wvalid = 1'b0;
    tick();
    tick();
    axi_awaddr = 32'h64; axi_awvalid = 1'b1;
    @(negedge clk);
    chk("aw_late_awready", 256'(axi_awready), 256'(1));
    tick();
    axi_awvalid = 1'b0;
    @(negedge clk);
    chk("b_not_early", 256'(axi_bvalid), 256'(0));
    tick();
    @(negedge clk);
    chk("b_rise", 256'(axi_bvalid), 256'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("b_hold_bvalid",  256'(axi_bvalid), 256'(1));
      chk("b_hold_awready", 256'(axi_awready), 256'(0));
      chk("b_hold_wready",  256'(axi_wready), 256'(0));
    end
    bq.push_back(2'b00);
    tick();
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    @(negedge clk);
    chk("b_released", 256'(axi_bvalid), 256'(0));
    tick();

    // Invalid index, masked byte lane, address bits outside [7:2]
    axi_wr(32'h70,        32'h33, 4'hF,    2'b10);
    axi_wr(32'h04,        32'h77, 4'b1110, 2'b00);
    axi_wr(32'h0B,        32'h80, 4'hF,    2'b00);
    axi_wr(32'hFFFF_FFFC, 32'h1,  4'hF,    2'b10);
    @(negedge clk);
    chk("bad_writes_no_pending", 256'(pending_o), 256'(0));
    chk("active_stable", 256'(coeff_o), 256'(exp_vec));
    tick();

    // Commit lands on the vs rising edge: copy deferred
    bq.push_back(2'b00);
    axi_awaddr = 32'h0001_0068; axi_wdata = 32'h1; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
    @(negedge clk);
    chk("sync_commit_ready", 256'({axi_awready, axi_wready}), 256'(2'b11));
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    vs_i = 1'b1;
    @(negedge clk);
    chk("sync_commit_b_early", 256'(axi_bvalid), 256'(0));
    tick();
    @(negedge clk);
    chk("sync_commit_pending", 256'(pending_o), 256'(1));
    chk("sync_commit_upd0", 256'(coeff_upd_o), 256'(0));
    tick();
    axi_bready = 1'b0;
    @(negedge clk);
    chk("sync_commit_no_copy", 256'(coeff_upd_o), 256'(0));
    chk("sync_commit_active", 256'(coeff_o), 256'(exp_vec));
    tick();
    vs_i = 1'b0;
    tick();
    axi_wr(32'h0C, 32'h12, 4'hF, 2'b00);   // shadow write while pending
    exp_vec[2*CW +: CW] = 8'h80;
    exp_vec[3*CW +: CW] = 8'h12;
    uq.push_back('{vec: exp_vec, sh: 4'd5});
    vs_edge();
    @(negedge clk);
    chk("deferred_pending_clr", 256'(pending_o), 256'(0));
    chk("deferred_coeff", 256'(coeff_o), 256'(exp_vec));
    chk("deferred_shift", 256'(shift_o), 256'(4'd5));
    tick();

    // Reset while committed: pending discarded, shadow back to defaults
    axi_wr(32'h10, 32'h22, 4'hF, 2'b00);
    axi_wr(32'h68, 32'h1,  4'hF, 2'b00);
    @(negedge clk);
    chk("pre_rst_pending", 256'(pending_o), 256'(1));
    tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_pending", 256'(pending_o), 256'(0));
    chk("post_rst_coeff", 256'(coeff_o), 256'(rst_vec));
    chk("post_rst_shift", 256'(shift_o), 256'(4'd4));
    chk("post_rst_bvalid", 256'(axi_bvalid), 256'(0));
    tick();
    vs_edge();                              // no pulse expected
    repeat (2) tick();
    axi_wr(32'h68, 32'h1, 4'hF, 2'b00);
    uq.push_back('{vec: rst_vec, sh: 4'd4});
    vs_edge();
    repeat (2) tick();

    chk("bq_drained", 256'(bq.size()), 256'(0));
    chk("uq_drained", 256'(uq.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
